// File: rtl/memtest_bist_display.sv
// rtl/memtest_bist_display.sv - memory BIST write/read-compare sequencer with hex seven-segment status readout
module memtest_bist_display #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 10,
  parameter int          DIGITS   = 4,
  parameter int          STEP_DIV = 1,
  parameter logic [15:0] SEED     = 16'hA5A5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          pat_sel,
  input  logic [1:0]          disp_sel,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic [7*DIGITS-1:0] seg
);
  localparam int DW    = 4 * DIGITS;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] ALT_5  = DATA_W'(64'h5555_5555_5555_5555);
  localparam logic [DATA_W-1:0] ALT_A  = DATA_W'(64'hAAAA_AAAA_AAAA_AAAA);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CMP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DW-1:0]      err_q, err_d;
  logic [ADDR_W-1:0]  ffa_q, ffa_d;
  logic [DATA_W-1:0]  last_rd_q, last_rd_d;
  logic [1:0]         pat_q, pat_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               busy_q, busy_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  logic               tick;
  logic [DATA_W-1:0]  expected;
  logic               mismatch;
  logic [DW-1:0]      disp_word;

  function automatic logic [DATA_W-1:0] pattern_of(input logic [1:0] sel, input logic [ADDR_W-1:0] a);
    case (sel)
      2'd0:    pattern_of = DATA_W'(a) ^ SEED_W;
      2'd1:    pattern_of = '0;
      2'd2:    pattern_of = '1;
      default: pattern_of = a[0] ? ALT_A : ALT_5;
    endcase
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign tick      = (div_q == DIV_W'(STEP_DIV - 1));
  assign expected  = pattern_of(pat_q, addr_q);
  assign mismatch  = (mem_rdata != expected);
  assign mem_addr  = addr_q;
  assign mem_wdata = expected;
  assign mem_we    = (state_q == S_WRITE) && tick && !rst;
  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

  // CMP occupies one step like READ, so every address costs two steps
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_d     = err_q;
    ffa_d     = ffa_q;
    last_rd_d = last_rd_q;
    pat_d     = pat_q;
    busy_d    = busy_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = '0;
          err_d   = '0;
          ffa_d   = '0;
          pat_d   = pat_sel;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          div_d   = '0;
        end
      end
      S_WRITE: begin
        if (tick) begin
          if (addr_q == '1) begin
            addr_d  = '0;
            state_d = S_READ;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (tick) state_d = S_CMP;
      end
      S_CMP: begin
        if (tick) begin
          last_rd_d = mem_rdata;
          if (mismatch) begin
            if (err_q == '0) ffa_d = addr_q;
            err_d = (err_q == '1) ? err_q : err_q + 1'b1;
          end
          if (addr_q == '1) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            pass_d  = (err_d == '0);
            fail_d  = (err_d != '0);
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      err_q     <= '0;
      ffa_q     <= '0;
      last_rd_q <= '0;
      pat_q     <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      ffa_q     <= ffa_d;
      last_rd_q <= last_rd_d;
      pat_q     <= pat_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    case (disp_sel)
      2'd0:    disp_word = DW'(last_rd_q);
      2'd1:    disp_word = err_q;
      2'd2:    disp_word = DW'(ffa_q);
      default: disp_word = DW'(addr_q);
    endcase
    seg = '0;
    for (int k = 0; k < DIGITS; k++) begin
      seg[7*k +: 7] = hex_glyph(disp_word[4*k +: 4]);
    end
  end
endmodule

// File: tb/tb_memtest_bist_display.sv
// tb/tb_memtest_bist_display.sv - randomized bench with a time-indexed behavioural model of the BIST
module tb_memtest_bist_display;
  localparam int D = 8;
  localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [15:0] EXP_W0 [8] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6,
                                         16'hA5A1, 16'hA5A0, 16'hA5A3, 16'hA5A2};
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0001110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, we_a, busy_a, pass_a, fail_a;
  logic [1:0]  pat_a, dsel_a;
  logic [2:0]  addr_a;
  logic [15:0] wdata_a, rdata_a;
  logic [27:0] seg_a;

  logic        rst_b, start_b, we_b, busy_b, pass_b, fail_b;
  logic [1:0]  pat_b, dsel_b;
  logic [2:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;
  logic [27:0] seg_b;

  logic        rst_c, start_c, we_c, busy_c, pass_c, fail_c;
  logic [1:0]  pat_c, dsel_c;
  logic [4:0]  addr_c;
  logic [15:0] wdata_c;
  logic [15:0] rdata_c = 16'h0000;
  logic [6:0]  seg_c;

  memtest_bist_display #(.DATA_W(16), .ADDR_W(3), .DIGITS(4), .STEP_DIV(1), .SEED(16'hA5A5)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .pat_sel(pat_a), .disp_sel(dsel_a),
    .mem_addr(addr_a), .mem_we(we_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
    .busy(busy_a), .pass(pass_a), .fail(fail_a), .seg(seg_a));

  memtest_bist_display #(.DATA_W(16), .ADDR_W(3), .DIGITS(4), .STEP_DIV(4), .SEED(16'hA5A5)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .pat_sel(pat_b), .disp_sel(dsel_b),
    .mem_addr(addr_b), .mem_we(we_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .busy(busy_b), .pass(pass_b), .fail(fail_b), .seg(seg_b));

  memtest_bist_display #(.DATA_W(16), .ADDR_W(5), .DIGITS(1), .STEP_DIV(1), .SEED(16'hA5A5)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .pat_sel(pat_c), .disp_sel(dsel_c),
    .mem_addr(addr_c), .mem_we(we_c), .mem_wdata(wdata_c), .mem_rdata(rdata_c),
    .busy(busy_c), .pass(pass_c), .fail(fail_c), .seg(seg_c));

  // RAM A has per-address stuck-at-1 masks on its read port
  logic [15:0] ram_a [D];
  logic [15:0] s1_a  [D];
  logic [15:0] ram_b [D];
  always @(posedge clk) begin
    if (we_a) ram_a[addr_a] <= wdata_a;
    rdata_a <= ram_a[addr_a] | s1_a[addr_a];
    if (we_b) ram_b[addr_b] <= wdata_b;
    rdata_b <= ram_b[addr_b];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat_f(input int p, input int i);
    case (p)
      0:       return 16'(i) ^ 16'hA5A5;
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      default: return (i % 2 == 1) ? 16'hAAAA : 16'h5555;
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] n);
    return ~LIT[n];
  endfunction

  function automatic logic [27:0] seg4(input logic [15:0] w);
    return {glyph(w[15:12]), glyph(w[11:8]), glyph(w[7:4]), glyph(w[3:0])};
  endfunction

  // Model: t counts cycles since the accepted start; writes at t=1..D, then READ/CMP pairs
  bit          chk_en = 0;
  bit          m_run = 0;
  int          m_t = 0;
  int          m_pat = 0;
  int          m_addr = 0;
  int          m_ffa = 0;
  logic [15:0] m_err = 16'h0;
  logic [15:0] m_last = 16'h0;
  bit          m_pass = 0;
  bit          m_fail = 0;

  always @(negedge clk) begin : compare_proc
    int          e_addr, a;
    bit          e_we, e_busy;
    logic [15:0] w, rd;
    if (chk_en) begin
      if (m_run) begin
        e_busy = 1;
        if (m_t <= D) begin e_addr = m_t - 1; e_we = 1; end
        else begin e_addr = (m_t - D - 1) / 2; e_we = 0; end
      end else begin
        e_busy = 0; e_we = 0; e_addr = m_addr;
      end
      if (rst_a) e_we = 0;
      check("busy", busy_a, e_busy);
      check("pass", pass_a, m_pass);
      check("fail", fail_a, m_fail);
      check("mem_we", we_a, e_we);
      check("mem_addr", addr_a, 64'(e_addr));
      check("mem_wdata", wdata_a, pat_f(m_pat, e_addr));
      case (dsel_a)
        2'd0:    w = m_last;
        2'd1:    w = m_err;
        2'd2:    w = 16'(m_ffa);
        default: w = 16'(e_addr);
      endcase
      check("seg", seg_a, seg4(w));

      if (rst_a) begin
        m_run = 0; m_t = 0; m_pat = 0; m_addr = 0; m_ffa = 0;
        m_err = 0; m_last = 0; m_pass = 0; m_fail = 0;
      end else if (m_run) begin
        if (m_t >= D + 2 && (m_t - D) % 2 == 0) begin
          a = (m_t - D - 2) / 2;
          rd = pat_f(m_pat, a) | s1_a[a];
          m_last = rd;
          if (rd != pat_f(m_pat, a)) begin
            if (m_err == 0) m_ffa = a;
            if (m_err != 16'hFFFF) m_err = m_err + 1;
          end
          if (a == D - 1) begin
            m_run = 0; m_addr = D - 1;
            m_pass = (m_err == 0); m_fail = (m_err != 0);
          end
        end
        m_t = m_t + 1;
      end else if (start_a) begin
        m_run = 1; m_t = 1; m_pat = pat_a; m_addr = 0; m_ffa = 0;
        m_err = 0; m_pass = 0; m_fail = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wq_a[$];
  int          fall_a;

  task automatic run_a(input int p, input bit noise, input int rst_at);
    wq_a.delete();
    fall_a = -1;
    pat_a = 2'(p);
    start_a = 1;
    rst_a = 0;
    dsel_a = 2'($urandom_range(0, 3));
    tick;
    start_a = 0;
    for (int n = 1; n <= 200; n++) begin
      if (we_a) wq_a.push_back(wdata_a);
      if (!busy_a) begin
        fall_a = n - 1;
        start_a = 0;
        rst_a = 0;
        break;
      end
      dsel_a = 2'($urandom_range(0, 3));
      start_a = noise && ($urandom_range(0, 3) == 0);
      rst_a = (n == rst_at);
      if (rst_a) begin
        #1;
        check("we_low_in_rst", we_a, 0);
      end
      tick;
    end
    start_a = 0;
    rst_a = 0;
  endtask

  task automatic show_a(input logic [1:0] sel);
    dsel_a = sel;
    tick;
  endtask

  initial begin : main
    int pulses, fall_b, fall_c, rst_at;
    rst_a = 1; rst_b = 1; rst_c = 1;
    start_a = 0; start_b = 0; start_c = 0;
    pat_a = 0; pat_b = 0; pat_c = 0;
    dsel_a = 0; dsel_b = 0; dsel_c = 0;
    for (int k = 0; k < D; k++) s1_a[k] = 16'h0;
    tick;
    chk_en = 1;
    tick;
    tick;
    check("rst_busy", busy_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_fail", fail_a, 0);
    check("rst_we", we_a, 0);
    check("rst_seg_a", seg_a, {4{G0}});
    check("rst_seg_c", seg_c, G0);
    rst_a = 0; rst_b = 0; rst_c = 0;
    tick;

    run_a(0, 0, 0);
    check("ideal_fall", fall_a, 24);
    check("ideal_nwrites", wq_a.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < wq_a.size()) check("ideal_wdata", wq_a[k], EXP_W0[k]);
    check("ideal_pass", pass_a, 1);
    check("ideal_fail", fail_a, 0);
    show_a(2'd0);
    check("ideal_last_rd", seg_a, {GA, G5, GA, G2});
    show_a(2'd1);
    check("ideal_err_cnt", seg_a, {4{G0}});

    s1_a[2] = 16'h0001;
    run_a(1, 0, 0);
    s1_a[2] = 16'h0000;
    check("stuck_fail", fail_a, 1);
    check("stuck_pass", pass_a, 0);
    show_a(2'd1);
    check("stuck_err_cnt", seg_a, {G0, G0, G0, G1});
    show_a(2'd2);
    check("stuck_first_addr", seg_a, {G0, G0, G0, G2});
    show_a(2'd0);
    check("stuck_last_rd", seg_a, {4{G0}});

    run_a(0, 1, 3);
    check("midrst_fall", fall_a, 3);
    check("midrst_nwrites", wq_a.size(), 3);
    check("midrst_busy", busy_a, 0);
    check("midrst_we", we_a, 0);
    check("midrst_addr", addr_a, 0);
    run_a(0, 1, 0);
    check("noise_fall", fall_a, 24);
    check("noise_nwrites", wq_a.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < wq_a.size()) check("noise_wdata", wq_a[k], EXP_W0[k]);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < D; k++)
        s1_a[k] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
      rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 0;
      run_a($urandom_range(0, 3), 1, rst_at);
      check("rand_fall", fall_a, (rst_at == 0) ? 24 : rst_at);
    end
    for (int k = 0; k < D; k++) s1_a[k] = 16'h0;

    start_b = 1;
    tick;
    start_b = 0;
    pulses = 0;
    fall_b = -1;
    for (int n = 1; n <= 400; n++) begin
      if (we_b) begin
        if (pulses < 8) check("div4_pulse_pos", n, 4 * (pulses + 1));
        pulses++;
      end
      if (!busy_b) begin fall_b = n - 1; break; end
      tick;
    end
    check("div4_pulses", pulses, 8);
    check("div4_fall", fall_b, 96);
    check("div4_pass", pass_b, 1);

    pat_c = 2;
    start_c = 1;
    tick;
    start_c = 0;
    fall_c = -1;
    for (int n = 1; n <= 400; n++) begin
      if (!busy_c) begin fall_c = n - 1; break; end
      tick;
    end
    check("sat_fall", fall_c, 96);
    check("sat_fail", fail_c, 1);
    check("sat_pass", pass_c, 0);
    dsel_c = 1;
    tick;
    check("sat_err_cnt", seg_c, GF);
    dsel_c = 2;
    tick;
    check("sat_first_addr", seg_c, G0);
    dsel_c = 3;
    tick;
    check("sat_addr", seg_c, GF);

    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
